// File: rtl/dmem_if.sv
// CPU data-port request/response bundle between the CPU (master) and a data
// memory (slave).
interface dmem_if;
  logic        valid;
  logic [31:0] addr;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mask_mode;
  logic        sext;
  logic [31:0] write_data;
  logic        good;
  logic [31:0] read_data;
  logic        err;

  modport master (
    output valid, addr, mem_read, mem_write, mask_mode, sext, write_data,
    input  good, read_data, err
  );

  modport slave (
    input  valid, addr, mem_read, mem_write, mask_mode, sext, write_data,
    output good, read_data, err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder for the CPU dmem port. It handles one request at a
// time, inserts wait states, and applies byte/half/word lane masking.
//
//   state    | meaning
//   S_IDLE   | waiting for a request; capture and classify it on valid
//   S_WAIT   | counting down the programmed wait states
//   S_ACCESS | write the enabled byte lanes or read the full word
//   S_RESP   | one-cycle good pulse; read_data/err hold afterwards
module dmem_responder #(
  parameter int          DEPTH_LOG2  = 12,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic  clk,
  input logic  rst_n,
  dmem_if.slave dmem
);

  localparam int unsigned WORDS     = 1 << DEPTH_LOG2;
  localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  state_t                state, state_nxt;
  logic [3:0]            cnt, cnt_nxt;
  logic [DEPTH_LOG2+1:0] off_q;
  logic [1:0]            size_q;
  logic                  sext_q;
  logic                  write_q;
  logic [31:0]           wdata_q;
  logic [31:0]           rdata_q;
  logic                  err_q;

  logic [31:0]           req_off;
  logic                  req_err;
  logic [DEPTH_LOG2-1:0] idx;
  logic [3:0]            be;
  logic [31:0]           lanes;
  logic [31:0]           rd_word;
  logic [31:0]           shifted;
  logic [31:0]           load_val;

  logic [31:0] mem [WORDS];

  // BASE_ADDR is aligned, so an address below the window wraps to a large
  // offset and is caught by the same upper-bit test as one above it.
  always_comb begin
    req_off = dmem.addr - BASE_ADDR;
    req_err = (dmem.mem_read == dmem.mem_write)
            | (dmem.mask_mode == 2'b11)
            | (dmem.mask_mode == 2'b01 && dmem.addr[0])
            | (dmem.mask_mode == 2'b10 && dmem.addr[1:0] != 2'b00)
            | (req_off[31:DEPTH_LOG2+2] != '0);
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (dmem.valid) begin
          if (req_err) begin
            state_nxt = S_RESP;
          end else if (WAIT_CYCLES == 0) begin
            state_nxt = S_ACCESS;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) state_nxt = S_ACCESS;
        else             cnt_nxt   = cnt - 4'd1;
      end
      S_ACCESS: state_nxt = S_RESP;
      S_RESP:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    idx     = off_q[DEPTH_LOG2+1:2];
    rd_word = mem[idx];
    shifted = rd_word >> {off_q[1:0], 3'b000};
    case (size_q)
      2'b00: begin
        be       = 4'b0001 << off_q[1:0];
        lanes    = {4{wdata_q[7:0]}};
        load_val = {{24{sext_q & shifted[7]}}, shifted[7:0]};
      end
      2'b01: begin
        be       = off_q[1] ? 4'b1100 : 4'b0011;
        lanes    = {2{wdata_q[15:0]}};
        load_val = {{16{sext_q & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        be       = 4'b1111;
        lanes    = wdata_q;
        load_val = rd_word;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      off_q   <= '0;
      size_q  <= 2'b00;
      sext_q  <= 1'b0;
      write_q <= 1'b0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == S_IDLE && dmem.valid) begin
        off_q   <= req_off[DEPTH_LOG2+1:0];
        size_q  <= dmem.mask_mode;
        sext_q  <= dmem.sext;
        write_q <= dmem.mem_write;
        wdata_q <= dmem.write_data;
      end
      if (state == S_IDLE && dmem.valid && req_err) begin
        err_q   <= 1'b1;
        rdata_q <= 32'd0;
      end else if (state == S_ACCESS) begin
        err_q   <= 1'b0;
        rdata_q <= write_q ? 32'd0 : load_val;
      end
    end
  end

  // Storage is deliberately outside the reset domain; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (state == S_ACCESS && write_q) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= lanes[8*b +: 8];
      end
    end
  end

  assign dmem.good      = (state == S_RESP);
  assign dmem.read_data = rdata_q;
  assign dmem.err       = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a byte-addressed reference memory
// predicts errors, load data and latency for random and directed requests.
module tb_dmem_responder;
  localparam int          D      = 6;
  localparam int          SPAN   = 4 << D;
  localparam logic [31:0] BASE_A = 32'h0000_0100;
  localparam logic [31:0] BASE_B = 32'h0000_0400;
  localparam int          WA     = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_if ia();
  dmem_if ib();

  dmem_responder #(.DEPTH_LOG2(D), .WAIT_CYCLES(WA), .BASE_ADDR(BASE_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .dmem(ia)
  );
  dmem_responder #(.DEPTH_LOG2(D), .WAIT_CYCLES(0), .BASE_ADDR(BASE_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .dmem(ib)
  );

  int total = 0;
  int bad = 0;
  logic [7:0] mb [SPAN];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit model_err(logic rd, logic wr, logic [1:0] mm, logic [31:0] a,
                                   logic [31:0] base);
    if (rd == wr) return 1'b1;
    if (mm == 2'd3) return 1'b1;
    if (mm == 2'd1 && (a % 2) != 0) return 1'b1;
    if (mm == 2'd2 && (a % 4) != 0) return 1'b1;
    if (a < base || a >= base + SPAN) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] extend(logic [31:0] v, int n, logic sx);
    logic [31:0] m;
    if (n >= 4) return v;
    m = 32'((64'd1 << (8 * n)) - 64'd1);
    v = v & m;
    if (sx && ((v >> (8 * n - 1)) & 32'd1) != 0) v = v | ~m;
    return v;
  endfunction

  task automatic do_a(input logic rd, input logic wr, input logic [1:0] mm, input logic sx,
                      input logic [31:0] addr, input logic [31:0] wdata, input bit drop);
    bit e;
    int n, off, lat, exp_lat;
    bit got;
    logic [31:0] exp_rd;
    e = model_err(rd, wr, mm, addr, BASE_A);
    n = 1 << mm;
    off = int'(addr - BASE_A);
    exp_rd = 32'd0;
    if (!e && rd) begin
      for (int k = 0; k < n; k++) exp_rd = exp_rd | (32'(mb[off + k]) << (8 * k));
      exp_rd = extend(exp_rd, n, sx);
    end
    exp_lat = e ? 1 : WA + 2;
    @(negedge clk);
    ia.addr = addr; ia.mem_read = rd; ia.mem_write = wr; ia.mask_mode = mm;
    ia.sext = sx; ia.write_data = wdata; ia.valid = 1'b1;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (ia.good) got = 1'b1;
      else if (drop) ia.valid = 1'b0;
    end
    ia.valid = 1'b0;
    chk("a_latency", 32'(lat), 32'(exp_lat));
    chk("a_err", 32'(ia.err), 32'(e));
    chk("a_rdata", ia.read_data, exp_rd);
    @(posedge clk);
    @(negedge clk);
    chk("a_good_pulse", 32'(ia.good), 32'd0);
    chk("a_rdata_hold", ia.read_data, exp_rd);
    if (!e && wr) for (int k = 0; k < n; k++) mb[off + k] = wdata[8*k +: 8];
  endtask

  initial begin
    logic [31:0] a, old;
    logic [1:0]  mm;
    logic        rd, wr;
    int          r;
    ia.valid = 0; ia.addr = 0; ia.mem_read = 0; ia.mem_write = 0;
    ia.mask_mode = 0; ia.sext = 0; ia.write_data = 0;
    ib.valid = 0; ib.addr = 0; ib.mem_read = 0; ib.mem_write = 0;
    ib.mask_mode = 0; ib.sext = 0; ib.write_data = 0;
    repeat (2) @(negedge clk);
    chk("rst_good_a", 32'(ia.good), 32'd0);
    chk("rst_err_a", 32'(ia.err), 32'd0);
    chk("rst_rdata_a", ia.read_data, 32'd0);
    chk("rst_good_b", 32'(ib.good), 32'd0);
    chk("rst_rdata_b", ib.read_data, 32'd0);
    rst_n = 1'b1;

    for (int w = 0; w < SPAN / 4; w++) do_a(0, 1, 2'd2, 0, BASE_A + 32'(4 * w), $urandom, 0);

    do_a(0, 1, 2'd2, 0, BASE_A + 32'h10, 32'hDEADBEEF, 0);
    do_a(1, 0, 2'd2, 0, BASE_A + 32'h10, 32'h0, 0);
    do_a(0, 1, 2'd2, 0, BASE_A + 32'h20, 32'h11223344, 0);
    do_a(0, 1, 2'd0, 0, BASE_A + 32'h21, 32'hABCDEF80, 0);
    do_a(1, 0, 2'd2, 0, BASE_A + 32'h20, 32'h0, 0);
    chk("lane_word", ia.read_data, 32'h11228044);
    do_a(1, 0, 2'd0, 1, BASE_A + 32'h21, 32'h0, 0);
    chk("byte_sext", ia.read_data, 32'hFFFFFF80);
    do_a(1, 0, 2'd0, 0, BASE_A + 32'h21, 32'h0, 0);
    chk("byte_zext", ia.read_data, 32'h00000080);
    do_a(1, 0, 2'd1, 1, BASE_A + 32'h22, 32'h0, 0);
    chk("half_sext", ia.read_data, 32'h00001122);

    do_a(0, 1, 2'd1, 0, BASE_A + 32'h21, 32'hFFFFFFFF, 0);
    do_a(0, 1, 2'd2, 0, BASE_A + 32'h22, 32'hFFFFFFFF, 0);
    do_a(0, 1, 2'd3, 0, BASE_A + 32'h20, 32'hFFFFFFFF, 0);
    do_a(1, 1, 2'd2, 0, BASE_A + 32'h20, 32'hFFFFFFFF, 0);
    do_a(0, 0, 2'd2, 0, BASE_A + 32'h20, 32'hFFFFFFFF, 0);
    do_a(0, 1, 2'd2, 0, BASE_A + SPAN, 32'hFFFFFFFF, 0);
    do_a(0, 1, 2'd2, 0, BASE_A - 32'd4, 32'hFFFFFFFF, 0);
    do_a(1, 0, 2'd2, 0, BASE_A + 32'h20, 32'h0, 0);
    chk("err_untouched", ia.read_data, 32'h11228044);

    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      if (r < 8) begin rd = 1'($urandom_range(0, 1)); wr = ~rd; end
      else begin rd = (r == 8); wr = (r == 8); end
      mm = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a = BASE_A + 32'($urandom_range(0, SPAN - 1));
      if ($urandom_range(0, 7) != 0) begin
        if (mm == 2'd1) a[0] = 1'b0;
        if (mm == 2'd2) a[1:0] = 2'b00;
      end
      if ($urandom_range(0, 15) == 0) a = ($urandom_range(0, 1) == 0) ? BASE_A - 32'd4
                                                                     : BASE_A + SPAN + 32'd4;
      do_a(rd, wr, mm, 1'($urandom_range(0, 1)), a, $urandom, bit'($urandom_range(0, 1)));
    end

    // Back-to-back stream on the zero-wait instance, valid held high throughout.
    begin
      logic [31:0] sa, sd;
      logic [1:0]  smm;
      logic        ssx;
      int          cnt;
      bit          got;
      @(negedge clk);
      for (int i = 0; i < 16; i++) begin
        if (i % 2 == 0) begin
          smm = 2'($urandom_range(0, 2));
          sa = BASE_B + 32'($urandom_range(0, SPAN / 4 - 1) * 4);
          if (smm == 2'd0) sa = sa + 32'($urandom_range(0, 3));
          if (smm == 2'd1) sa = sa + 32'($urandom_range(0, 1) * 2);
          sd = $urandom;
          ssx = 1'($urandom_range(0, 1));
        end
        ib.addr = sa; ib.mask_mode = smm; ib.sext = ssx; ib.write_data = sd;
        ib.mem_write = (i % 2 == 0); ib.mem_read = (i % 2 == 1); ib.valid = 1'b1;
        cnt = 0;
        got = 1'b0;
        while (!got && cnt < 10) begin
          @(posedge clk);
          cnt++;
          @(negedge clk);
          if (ib.good) got = 1'b1;
        end
        chk("b_spacing", 32'(cnt), (i == 0) ? 32'd2 : 32'd3);
        chk("b_err", 32'(ib.err), 32'd0);
        chk("b_rdata", ib.read_data, (i % 2 == 0) ? 32'd0 : extend(sd, 1 << smm, ssx));
      end
      ib.valid = 1'b0;
    end

    // Reset during the wait state of a store: the store must be dropped.
    do_a(1, 0, 2'd2, 0, BASE_A + 32'h40, 32'h0, 0);
    old = {mb[67], mb[66], mb[65], mb[64]};
    @(negedge clk);
    ia.addr = BASE_A + 32'h40; ia.mem_read = 0; ia.mem_write = 1; ia.mask_mode = 2'd2;
    ia.sext = 0; ia.write_data = ~old; ia.valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("pre_rst_good", 32'(ia.good), 32'd0);
    rst_n = 1'b0;
    ia.valid = 1'b0;
    #1;
    chk("rst_mid_good", 32'(ia.good), 32'd0);
    chk("rst_mid_err", 32'(ia.err), 32'd0);
    chk("rst_mid_rdata", ia.read_data, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_hold_good", 32'(ia.good), 32'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_good", 32'(ia.good), 32'd0);
    end
    do_a(1, 0, 2'd2, 0, BASE_A + 32'h40, 32'h0, 0);
    chk("rst_store_dropped", ia.read_data, old);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
